transpad_mem_resp: RTL
======================

Name: transpad_mem_resp

Overview:
Memory-side responder for the transpad address-generation unit.
- Consumes the translated address stream (addr/act/spm) and steers each access to the scratchpad (SPM) or to main memory.
- Models per-target access latency and returns the rdy handshake that lets transpad advance.
- Keeps access statistics and a sticky protocol-error flag.

Parameters:
ADDR_W, 16, address width; matches transpad output width
SPM_LAT, 1, SPM access latency in cycles; legal range 1..15
MM_LAT, 4, main-memory access latency in cycles; legal range 1..15
COUNT_W, 16, width of the statistics counters

Ports:
clk  input  1  clock, all logic rising-edge
rst  input  1  reset, asynchronous, active-high
addr  input  ADDR_W  translated address from transpad
act  input  1  access request valid
spm  input  1  1 = scratchpad target, 0 = main memory
mm_stall  input  1  main-memory backpressure; freezes the MM latency count
rdy  output  1  access complete, one-cycle pulse back to transpad
spm_re  output  1  SPM read strobe, one-cycle pulse
spm_addr  output  ADDR_W  SPM address, valid while spm_re=1
mm_re  output  1  main-memory read strobe, one-cycle pulse
mm_addr  output  ADDR_W  main-memory address, valid while mm_re=1
n_spm  output  COUNT_W  completed SPM accesses, saturating
n_mm  output  COUNT_W  completed MM accesses, saturating
err  output  1  sticky protocol-violation flag

Behaviour:
- Reset (async, any state): state=IDLE; rdy, spm_re, mm_re, err = 0; spm_addr, mm_addr, n_spm, n_mm = 0; latency counter = 0. Any in-flight access is discarded with no rdy.
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE: on an edge with act=1, capture addr and spm into internal registers and go to ISSUE. act=0 stays in IDLE.
- ISSUE (1 cycle):
  - If captured spm=1: spm_re=1, spm_addr=captured addr.
  - If captured spm=0: mm_re=1, mm_addr=captured addr.
  - Load the counter with the target latency minus 1.
  - Next state is WAIT if the loaded value is nonzero, else DONE.
- WAIT: counter decrements each cycle. For an MM access it holds while mm_stall=1; mm_stall is ignored for SPM accesses. Go to DONE on the edge where the counter is 1 and decrementing.
- DONE (1 cycle): rdy=1. Increment n_spm or n_mm; both saturate at all-ones with no wrap. Next state IDLE.
- Latency: act first sampled at edge E0, then strobe in cycle E0+1 and rdy in cycle E0+LAT+1, plus one cycle per stalled MM cycle.
- Minimum spacing: next capture no earlier than the edge ending the cycle after DONE, i.e. one IDLE bubble.
- Handshake rules: the initiator holds act, addr and spm stable from capture until rdy.
  - act=0 during ISSUE/WAIT/DONE sets err.
  - addr or spm differing from the captured value during those states sets err.
  - The access still completes with the captured values, and rdy still pulses.
- err clears only on rst.
- Strobes are mutually exclusive. spm_addr and mm_addr hold their last value between strobes.
- SPM_LAT or MM_LAT outside 1..15: elaboration error via assertion.

Decomposition:
- Shared package transpad_pkg:
  - state enum resp_state_t {IDLE, ISSUE, WAIT, DONE};
  - LAT_W=4 constant;
  - latency-legal function for the parameter check.
- One sub-module, transpad_lat_cnt: loadable down-counter with a hold enable and an is_one output. It is instantiated once.
- The FSM, capture registers, strobes, statistics and err stay in transpad_mem_resp.

Test Plan:
- Reset: assert rst mid-cycle with no clock edge -> all outputs 0 immediately. Deassert, act=0 for 10 cycles -> rdy never asserts, counters stay 0.
- SPM access, SPM_LAT=1: act=1, spm=1, addr=0x1234 sampled at E0 -> spm_re=1 and spm_addr=0x1234 in cycle E0+1, rdy=1 in cycle E0+2 only, n_spm=1, mm_re never asserts.
- MM access, MM_LAT=4, with mm_stall=1 for 2 cycles during WAIT: addr=0x00FF, spm=0 -> mm_re and mm_addr=0x00FF in E0+1, rdy in E0+7, n_mm=1.
- Protocol violation: act dropped to 0 one cycle after capture of an MM access -> err=1 from the next cycle, rdy still pulses at E0+5, err stays 1 through 20 further idle cycles.
- Reset mid-access: rst pulsed during WAIT of an MM access -> no rdy, no counter increment. A new SPM access afterwards completes normally with n_spm=1.
- Saturation with COUNT_W=4: 17 back-to-back SPM accesses -> n_spm reaches 15 and holds, rdy pulses 17 times, each spaced SPM_LAT+2 cycles apart.

Source files
------------

// File: rtl/transpad_pkg.sv
// Shared types and constants for the transpad memory responder.
// Holds the FSM encoding, latency counter width and parameter check.
package transpad_pkg;

  localparam int LAT_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } resp_state_t;

  function automatic bit lat_legal(input int lat);
    return (lat >= 1) && (lat <= 15);
  endfunction

endpackage

// File: rtl/transpad_lat_cnt.sv
// Loadable down-counter timing one memory access.
// Counts down while enabled and not held; flags the final cycle.
module transpad_lat_cnt
  import transpad_pkg::*;
#(
  parameter int W = LAT_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  input  logic         hold,
  output logic         is_one
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && !hold && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign is_one = (cnt == W'(1));

endmodule

// File: rtl/transpad_mem_resp.sv
// Memory-side responder for transpad: steers accesses to SPM or MM,
// models latency, returns rdy, keeps stats and a sticky error flag.
module transpad_mem_resp
  import transpad_pkg::*;
#(
  parameter int ADDR_W  = 16,
  parameter int SPM_LAT = 1,
  parameter int MM_LAT  = 4,
  parameter int COUNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [ADDR_W-1:0]  addr,
  input  logic               act,
  input  logic               spm,
  input  logic               mm_stall,
  output logic               rdy,
  output logic               spm_re,
  output logic [ADDR_W-1:0]  spm_addr,
  output logic               mm_re,
  output logic [ADDR_W-1:0]  mm_addr,
  output logic [COUNT_W-1:0] n_spm,
  output logic [COUNT_W-1:0] n_mm,
  output logic               err
);

  if (!lat_legal(SPM_LAT)) begin : g_bad_spm_lat
    $error("SPM_LAT must be in 1..15");
  end
  if (!lat_legal(MM_LAT)) begin : g_bad_mm_lat
    $error("MM_LAT must be in 1..15");
  end

  localparam logic [LAT_W-1:0] SPM_M1 = LAT_W'(SPM_LAT - 1);
  localparam logic [LAT_W-1:0] MM_M1  = LAT_W'(MM_LAT - 1);

  resp_state_t       state;
  logic [ADDR_W-1:0] cap_addr;
  logic              cap_spm;
  logic [LAT_W-1:0]  lat_m1;
  logic              busy;
  logic              hold;
  logic              is_one;
  logic              violate;

  assign lat_m1  = cap_spm ? SPM_M1 : MM_M1;
  assign busy    = (state != IDLE);
  // Backpressure only applies to main memory.
  assign hold    = !cap_spm && mm_stall;
  assign violate = !act || (addr != cap_addr) || (spm != cap_spm);

  assign spm_re = (state == ISSUE) && cap_spm;
  assign mm_re  = (state == ISSUE) && !cap_spm;
  assign rdy    = (state == DONE);

  transpad_lat_cnt #(
    .W(LAT_W)
  ) u_lat_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (state == ISSUE),
    .load_val (lat_m1),
    .en       (state == WAIT),
    .hold     (hold),
    .is_one   (is_one)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cap_addr <= '0;
      cap_spm  <= 1'b0;
      spm_addr <= '0;
      mm_addr  <= '0;
      n_spm    <= '0;
      n_mm     <= '0;
      err      <= 1'b0;
    end else begin
      if (busy && violate) begin
        err <= 1'b1;
      end
      unique case (state)
        IDLE: begin
          if (act) begin
            cap_addr <= addr;
            cap_spm  <= spm;
            if (spm) begin
              spm_addr <= addr;
            end else begin
              mm_addr <= addr;
            end
            state <= ISSUE;
          end
        end
        ISSUE: begin
          state <= (lat_m1 != '0) ? WAIT : DONE;
        end
        WAIT: begin
          if (is_one && !hold) begin
            state <= DONE;
          end
        end
        DONE: begin
          if (cap_spm) begin
            if (n_spm != '1) n_spm <= n_spm + 1'b1;
          end else begin
            if (n_mm != '1) n_mm <= n_mm + 1'b1;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
